// File: rtl/bench_stim_sequencer_if.sv
// Handshake bundle between a stimulus source/result sink and the benchmark sequencer.
// The master side offers vectors and consumes results; the slave side is the sequencer.
interface bench_stim_sequencer_if #(
    parameter int IN_W  = 56,
    parameter int OUT_W = 23
);
    logic             vec_valid;
    logic             vec_ready;
    logic [IN_W-1:0]  vec_data;
    logic [3:0]       settle_cycles;
    logic             res_valid;
    logic             res_ready;
    logic [OUT_W-1:0] res_data;
    logic [5:0]       res_in_tog;
    logic [4:0]       res_out_tog;

    modport master (
        output vec_valid, vec_data, settle_cycles, res_ready,
        input  vec_ready, res_valid, res_data, res_in_tog, res_out_tog
    );

    modport slave (
        input  vec_valid, vec_data, settle_cycles, res_ready,
        output vec_ready, res_valid, res_data, res_in_tog, res_out_tog
    );
endinterface

// File: rtl/bench_stim_sequencer.sv
// Applies one stimulus vector at a time to a combinational benchmark, waits a
// programmable settle time, captures the response and accumulates toggle counts.
//
// state   | meaning
// IDLE    | ready for a new vector
// SETTLE  | dut_in driven, counting down settle time
// CAPTURE | sample dut_out, update toggle counts and accumulator
// RESP    | result held until res_ready
module bench_stim_sequencer #(
    parameter int IN_W  = 56,
    parameter int OUT_W = 23,
    parameter int ACC_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bench_stim_sequencer_if.slave bus,
    output logic [IN_W-1:0]      dut_in,
    input  logic [OUT_W-1:0]     dut_out,
    output logic [ACC_W-1:0]     acc_tog,
    input  logic                 clear_acc,
    output logic                 busy
);
    localparam int SUM_W = ACC_W + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, RESP} state_t;

    state_t           state, state_nxt;
    logic [3:0]       cnt;
    logic [OUT_W-1:0] prev_out;
    logic [OUT_W-1:0] res_data;
    logic [5:0]       res_in_tog;
    logic [4:0]       res_out_tog;
    logic             accept;
    logic [4:0]       out_tog_nxt;
    logic [SUM_W-1:0] acc_sum;

    assign accept      = (state == IDLE) && bus.vec_valid;
    assign out_tog_nxt = 5'($countones(dut_out ^ prev_out));
    assign acc_sum     = {1'b0, acc_tog} + SUM_W'(res_in_tog) + SUM_W'(out_tog_nxt);

    assign bus.vec_ready   = (state == IDLE);
    assign bus.res_valid   = (state == RESP);
    assign bus.res_data    = res_data;
    assign bus.res_in_tog  = res_in_tog;
    assign bus.res_out_tog = res_out_tog;
    assign busy            = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.vec_valid) state_nxt = SETTLE;
            SETTLE:  if (cnt == 4'd0) state_nxt = CAPTURE;
            CAPTURE: state_nxt = RESP;
            RESP:    if (bus.res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            dut_in      <= '0;
            prev_out    <= '0;
            res_data    <= '0;
            res_in_tog  <= '0;
            res_out_tog <= '0;
            acc_tog     <= '0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                dut_in     <= bus.vec_data;
                res_in_tog <= 6'($countones(bus.vec_data ^ dut_in));
                cnt        <= bus.settle_cycles;
            end else if (state == SETTLE && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (state == CAPTURE) begin
                res_data    <= dut_out;
                res_out_tog <= out_tog_nxt;
                prev_out    <= dut_out;
            end

            // clear wins over a same-cycle capture add
            if (clear_acc)
                acc_tog <= '0;
            else if (state == CAPTURE)
                acc_tog <= acc_sum[ACC_W] ? ACC_MAX : acc_sum[ACC_W-1:0];
        end
    end
endmodule

// File: tb/tb_bench_stim_sequencer.sv
// Directed and randomized bench for bench_stim_sequencer; expected results come
// from a vector-level model of toggle counts and a saturating accumulator.
module tb_bench_stim_sequencer;
    localparam int IN_W  = 56;
    localparam int OUT_W = 23;
    localparam int ACC_W = 8;
    localparam int ACC_MAX = (1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear_acc = 1'b0;
    logic [IN_W-1:0]  dut_in;
    logic [OUT_W-1:0] dut_out = '0;
    logic [ACC_W-1:0] acc_tog;
    logic             busy;

    bench_stim_sequencer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    bench_stim_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dut_in    (dut_in),
        .dut_out   (dut_out),
        .acc_tog   (acc_tog),
        .clear_acc (clear_acc),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // reference model state: last applied vector, last captured response, accumulator
    logic [IN_W-1:0]  m_in   = '0;
    logic [OUT_W-1:0] m_prev = '0;
    int               m_acc  = 0;

    function automatic int pop(input logic [63:0] x);
        int c = 0;
        for (int i = 0; i < 64; i++) c += int'(x[i]);
        return c;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [IN_W-1:0] v, input logic [3:0] s, input logic [OUT_W-1:0] o,
                        input int hold, input bit early, input bit clr);
        int lat;
        int e_in;
        int e_out;
        logic [34:0] snap;
        e_in  = pop(64'(v ^ m_in));
        e_out = pop(64'(o ^ m_prev));
        m_in   = v;
        m_prev = o;
        if (clr)                          m_acc = 0;
        else if (m_acc + e_in + e_out > ACC_MAX) m_acc = ACC_MAX;
        else                              m_acc = m_acc + e_in + e_out;

        check("vec_ready_idle", 64'(bus.vec_ready), 64'(1));
        bus.vec_valid     = 1'b1;
        bus.vec_data      = v;
        bus.settle_cycles = s;
        bus.res_ready     = early;
        dut_out           = o;
        @(negedge clk);
        bus.vec_valid     = 1'b0;
        bus.vec_data      = IN_W'({$urandom, $urandom});
        bus.settle_cycles = 4'($urandom);
        check("dut_in_drive", 64'(dut_in), 64'(v));
        check("busy_active", 64'(busy), 64'(1));

        lat = 0;
        while (!bus.res_valid && lat < 40) begin
            if (clr && lat == int'(s) + 1) clear_acc = 1'b1;
            @(negedge clk);
            clear_acc = 1'b0;
            lat++;
        end
        check("latency", 64'(lat), 64'(int'(s) + 2));
        check("res_data", 64'(bus.res_data), 64'(o));
        check("res_in_tog", 64'(bus.res_in_tog), 64'(e_in));
        check("res_out_tog", 64'(bus.res_out_tog), 64'(e_out));
        check("acc_tog", 64'(acc_tog), 64'(m_acc));

        if (!early) begin
            snap = {bus.res_valid, bus.res_data, bus.res_in_tog, bus.res_out_tog};
            for (int i = 0; i < hold; i++) begin
                bus.vec_valid = 1'($urandom_range(0, 1));
                bus.vec_data  = IN_W'({$urandom, $urandom});
                @(negedge clk);
                check("resp_stable", 64'({bus.res_valid, bus.res_data, bus.res_in_tog, bus.res_out_tog}),
                      64'(snap));
                check("vec_ready_busy", 64'(bus.vec_ready), 64'(0));
                check("dut_in_hold", 64'(dut_in), 64'(v));
            end
            bus.vec_valid = 1'b0;
            bus.res_ready = 1'b1;
        end
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("res_valid_drop", 64'(bus.res_valid), 64'(0));
        check("busy_idle", 64'(busy), 64'(0));
    endtask

    initial begin
        bus.vec_valid     = 1'b0;
        bus.vec_data      = '0;
        bus.settle_cycles = '0;
        bus.res_ready     = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_dut_in", 64'(dut_in), 64'(0));
        check("rst_res_valid", 64'(bus.res_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_acc", 64'(acc_tog), 64'(0));
        check("rst_res_fields", 64'({bus.res_data, bus.res_in_tog, bus.res_out_tog}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 64'(bus.vec_ready), 64'(1));

        // directed first vectors from reset
        send(IN_W'(56'h3), 4'd0, OUT_W'(23'h5), 0, 1'b0, 1'b0);
        check("acc_first", 64'(acc_tog), 64'(4));
        send(IN_W'(56'h1), 4'd5, OUT_W'(23'h4), 10, 1'b0, 1'b0);
        check("acc_second", 64'(acc_tog), 64'(6));

        // clear during capture, out toggles still reported
        send(IN_W'({$urandom, $urandom}), 4'd2, OUT_W'($urandom), 2, 1'b0, 1'b1);
        check("acc_cleared", 64'(acc_tog), 64'(0));

        for (int k = 0; k < 8; k++)
            send(IN_W'({$urandom, $urandom}), 4'($urandom_range(0, 15)), OUT_W'($urandom),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);

        // reset in the middle of SETTLE
        bus.vec_valid     = 1'b1;
        bus.vec_data      = IN_W'({$urandom, $urandom}) | IN_W'(1);
        bus.settle_cycles = 4'd8;
        dut_out           = OUT_W'($urandom);
        @(negedge clk);
        bus.vec_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_valid", 64'(bus.res_valid), 64'(0));
        check("midrst_dut_in", 64'(dut_in), 64'(0));
        check("midrst_acc", 64'(acc_tog), 64'(0));
        check("midrst_fields", 64'({bus.res_data, bus.res_in_tog, bus.res_out_tog}), 64'(0));
        m_in   = '0;
        m_prev = '0;
        m_acc  = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("midrst_no_result", 64'({bus.res_valid, acc_tog}), 64'(0));
        send(IN_W'(56'h3), 4'd0, OUT_W'(23'h5), 1, 1'b0, 1'b0);
        check("post_rst_acc", 64'(acc_tog), 64'(4));

        // saturation with all-bit toggles
        for (int k = 0; k < 20; k++)
            send((k % 2 == 0) ? ~m_in : ~m_in, 4'd0, ~m_prev, 0, 1'b1, 1'b0);
        check("acc_saturated", 64'(acc_tog), 64'(255));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
